dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Priority encoder/arbiter for the 4-channel DMA controller.
- Inputs: external DREQ lines, software request bits, mask bits and command-register priority/polarity bits.
- Selects one channel to own the shared address/word-count datapath.
- Drives ValidReqID/ReqID into the control interface (PE side) and holds the grant until timing control signals end of service; then updates fixed or rotating priority.

Parameters:
- SYNC_STAGES, 2, number of DREQ synchronizer flops (legal 1..3).

Ports:
- CLK  input  1  system clock
- RESET_N  input  1  asynchronous active-low reset
- DREQ  input  4  external DMA request lines, asynchronous to CLK
- DreqActiveLow  input  1  command bit 6: 1 = DREQ active low
- RotatingPriority  input  1  command bit 4: 1 = rotating, 0 = fixed (ch0 highest)
- MaskBits  input  4  mask register, 1 = channel masked
- SwReq  input  4  software request register bits, already synchronous
- ArbEnable  input  1  timing control is idle and may accept a new grant
- ServiceDone  input  1  one-cycle pulse: current channel service ended
- MasterClear  input  1  synchronous clear from control interface
- ValidReqID  output  1  grant valid
- ReqID  output  2  granted channel

Behaviour:
- Reset (RESET_N low, async) and MasterClear (sync, priority over all other inputs): state IDLE, ValidReqID=0, ReqID=0, TopPri=0, synchronizer flops cleared to the inactive level (0 after polarity).
- DREQ path: each bit is XORed with DreqActiveLow, then passed through SYNC_STAGES flops. SwReq and MaskBits are not synchronized.
- EffReq[i] = (SyncDreq[i] | SwReq[i]) & ~MaskBits[i].
- Priority order starts at TopPri and ascends modulo 4.
  - Fixed mode: TopPri is ignored and 0 is used.
  - Winner = first channel in that order with EffReq set.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if ArbEnable & |EffReq, then on the next edge ReqID=winner, ValidReqID=1, go to GRANT. Otherwise stay, ValidReqID=0, ReqID holds its last value.
  - GRANT: ReqID and ValidReqID held constant. Changes to DREQ, SwReq or MaskBits (including masking or dropping the granted channel) are ignored. Timing control ends service via ServiceDone. ArbEnable is ignored. On ServiceDone: ValidReqID=0 on the next edge, go to RELEASE.
    - Rotating mode: TopPri = ReqID+1 mod 4 at the same edge, so the serviced channel becomes lowest priority.
    - Fixed mode: TopPri unchanged.
  - RELEASE: exactly one cycle, ValidReqID=0, then IDLE. This guarantees ValidReqID is low for at least 2 cycles between grants.
- ServiceDone in IDLE or RELEASE is ignored: no priority update.
- Grant latency:
  - Software request: one CLK edge from SwReq/ArbEnable to ValidReqID.
  - External DREQ: SYNC_STAGES+1 edges from DREQ to ValidReqID.
- Simultaneous ServiceDone and new requests in GRANT: release always wins. The new request is arbitrated in IDLE with the updated TopPri.
- Changing RotatingPriority mid-grant takes effect at the next IDLE arbitration. TopPri is retained but unused while in fixed mode.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset/clear: assert RESET_N=0 mid-GRANT -> ValidReqID=0, ReqID=0 immediately. Repeat with MasterClear=1 -> outputs 0 on the next edge, next grant uses TopPri=0.
- Fixed priority: RotatingPriority=0, DreqActiveLow=0, DREQ=4'b1010, ArbEnable=1 -> ValidReqID=1, ReqID=1 after 3 edges. Pulse ServiceDone, keep DREQ -> ValidReqID low 2 cycles, then ReqID=1 again.
- Rotating priority: RotatingPriority=1, DREQ=4'b1111 held, pulse ServiceDone each grant -> ReqID sequence 0,1,2,3,0.
- Mask and software request: MaskBits=4'b0001, DREQ=4'b0001, SwReq=4'b0100 -> ReqID=2 after 1 edge. Set MaskBits=4'b0100 during GRANT -> ReqID=2 and ValidReqID=1 held until ServiceDone.
- Polarity: DreqActiveLow=1, DREQ=4'b1110 -> ReqID=0. DREQ=4'b1111 -> no grant, ValidReqID stays 0.
- Gating and edge cases: requests with ArbEnable=0 -> no grant until ArbEnable=1. ServiceDone pulsed in IDLE with RotatingPriority=1 -> TopPri unchanged (DREQ=4'b1111 then grants ReqID=0).

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter. Grants are fixed (ch0 highest) or rotating, and each grant is held until service ends.
// Latency: SwReq to grant takes 1 edge; DREQ to grant takes SYNC_STAGES+1 edges. All outputs are registered.
// Backpressure: ArbEnable gates new grants. A grant is held until ServiceDone, then the grant line stays low for at least 2 cycles.
module dma_priority_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic       DreqActiveLow,
  input  logic       RotatingPriority,
  input  logic [3:0] MaskBits,
  input  logic [3:0] SwReq,
  input  logic       ArbEnable,
  input  logic       ServiceDone,
  input  logic       MasterClear,
  output logic       ValidReqID,
  output logic [1:0] ReqID
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  logic [3:0] syncFf [SYNC_STAGES];
  logic [1:0] topPri;
  logic [1:0] startPri;
  logic [1:0] idx;
  logic [1:0] winner;
  logic [3:0] effReq;

  // Polarity is normalised before the first flop, so cleared flops read as "no request".
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncFf[s] <= '0;
    end else if (MasterClear) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncFf[s] <= '0;
    end else begin
      syncFf[0] <= DREQ ^ {4{DreqActiveLow}};
      for (int s = 1; s < SYNC_STAGES; s++) syncFf[s] <= syncFf[s-1];
    end
  end

  assign effReq   = (syncFf[SYNC_STAGES-1] | SwReq) & ~MaskBits;
  assign startPri = RotatingPriority ? topPri : 2'd0;

  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    winner = startPri;
    idx    = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = startPri + 2'(k);
      if (effReq[idx]) winner = idx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ValidReqID <= 1'b0;
      ReqID      <= 2'd0;
      topPri     <= 2'd0;
    end else if (MasterClear) begin
      state      <= IDLE;
      ValidReqID <= 1'b0;
      ReqID      <= 2'd0;
      topPri     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ArbEnable && (|effReq)) begin
            ReqID      <= winner;
            ValidReqID <= 1'b1;
            state      <= GRANT;
          end else begin
            ValidReqID <= 1'b0;
          end
        end
        GRANT: begin
          if (ServiceDone) begin
            ValidReqID <= 1'b0;
            state      <= RELEASE;
            // The channel just serviced drops to lowest priority.
            if (RotatingPriority) topPri <= ReqID + 2'd1;
          end
        end
        RELEASE: begin
          ValidReqID <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          ValidReqID <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios plus random traffic, checked against a cycle-level reference model.
module tb_dma_priority_arbiter;
  localparam int SS = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic       DreqActiveLow = 1'b0;
  logic       RotatingPriority = 1'b0;
  logic [3:0] MaskBits = '0;
  logic [3:0] SwReq = '0;
  logic       ArbEnable = 1'b0;
  logic       ServiceDone = 1'b0;
  logic       MasterClear = 1'b0;
  logic       ValidReqID;
  logic [1:0] ReqID;

  dma_priority_arbiter #(.SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DreqActiveLow(DreqActiveLow),
    .RotatingPriority(RotatingPriority), .MaskBits(MaskBits), .SwReq(SwReq),
    .ArbEnable(ArbEnable), .ServiceDone(ServiceDone), .MasterClear(MasterClear),
    .ValidReqID(ValidReqID), .ReqID(ReqID)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: mode 0 = waiting, 1 = channel owned, 2 = cool-down cycle.
  int mMode, mTop, mId, mVld;
  int dreqDelay[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    mMode = 0; mTop = 0; mId = 0; mVld = 0;
    dreqDelay.delete();
    for (int i = 0; i < SS; i++) dreqDelay.push_back(0);
  endtask

  function automatic int pickChannel(input int req, input int top);
    for (int k = 0; k < 4; k++)
      if ((req >> ((top + k) % 4)) & 1) return (top + k) % 4;
    return -1;
  endfunction

  task automatic modelEdge();
    int eff;
    if (MasterClear) begin
      modelClear();
      return;
    end
    eff = (dreqDelay[0] | int'(SwReq)) & ~int'(MaskBits) & 15;
    if (mMode == 0) begin
      if (ArbEnable && eff != 0) begin
        mId = pickChannel(eff, RotatingPriority ? mTop : 0);
        mVld = 1; mMode = 1;
      end
    end else if (mMode == 1) begin
      if (ServiceDone) begin
        mVld = 0; mMode = 2;
        if (RotatingPriority) mTop = (mId + 1) % 4;
      end
    end else begin
      mMode = 0;
    end
    void'(dreqDelay.pop_front());
    dreqDelay.push_back(int'(DREQ) ^ (DreqActiveLow ? 15 : 0));
  endtask

  task automatic tick();
    modelEdge();
    @(posedge CLK);
    #1;
    check("model_vld", ValidReqID, mVld);
    check("model_id", ReqID, mId);
  endtask

  task automatic waitGrant(input string tag, input int maxCycles);
    int n = 0;
    while (!ValidReqID && n < maxCycles) begin
      tick();
      n++;
    end
    check(tag, ValidReqID, 1);
  endtask

  task automatic serviceDone();
    ServiceDone = 1'b1;
    tick();
    ServiceDone = 1'b0;
  endtask

  task automatic clearPulse();
    MasterClear = 1'b1;
    tick();
    MasterClear = 1'b0;
  endtask

  initial begin
    int seq[5] = '{0, 1, 2, 3, 0};
    modelClear();
    #2;
    check("reset_vld", ValidReqID, 0);
    check("reset_id", ReqID, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Fixed priority through the DREQ synchronizer.
    DREQ = 4'b1010; ArbEnable = 1'b1;
    tick(); tick();
    check("fix_early", ValidReqID, 0);
    tick();
    check("fix_grant_vld", ValidReqID, 1);
    check("fix_grant_id", ReqID, 1);
    repeat (3) tick();
    check("fix_hold", ReqID, 1);
    serviceDone();
    check("fix_gap1", ValidReqID, 0);
    tick();
    check("fix_gap2", ValidReqID, 0);
    tick();
    check("fix_regrant_vld", ValidReqID, 1);
    check("fix_regrant_id", ReqID, 1);

    // Rotating priority visits every channel in turn.
    clearPulse();
    RotatingPriority = 1'b1; DREQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waitGrant("rot_wait", 6);
      check("rot_seq", ReqID, seq[g]);
      tick();
      serviceDone();
    end
    waitGrant("rot_wait_last", 6);
    check("rot_after_wrap", ReqID, 1);
    MasterClear = 1'b1;
    tick();
    MasterClear = 1'b0;
    check("clr_vld", ValidReqID, 0);
    check("clr_id", ReqID, 0);
    waitGrant("clr_wait", 6);
    check("clr_toppri0", ReqID, 0);

    // Software request on a masked-DREQ setup; masking mid-grant is ignored.
    clearPulse();
    RotatingPriority = 1'b0; DREQ = 4'b0001; MaskBits = 4'b0001; SwReq = 4'b0100;
    tick();
    check("sw_vld", ValidReqID, 1);
    check("sw_id", ReqID, 2);
    MaskBits = 4'b0100;
    repeat (3) tick();
    check("mask_hold_vld", ValidReqID, 1);
    check("mask_hold_id", ReqID, 2);
    serviceDone();
    check("mask_release", ValidReqID, 0);

    // Active-low DREQ polarity.
    clearPulse();
    MaskBits = '0; SwReq = '0; DreqActiveLow = 1'b1; DREQ = 4'b1110;
    waitGrant("pol_wait", 5);
    check("pol_id", ReqID, 0);
    DREQ = 4'b1111;
    serviceDone();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("pol_idle", ValidReqID, 0);
    end

    // ArbEnable gating.
    DreqActiveLow = 1'b0; ArbEnable = 1'b0; DREQ = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_off", ValidReqID, 0);
    end
    ArbEnable = 1'b1;
    tick();
    check("gate_on_vld", ValidReqID, 1);
    check("gate_on_id", ReqID, 2);
    serviceDone();

    // ServiceDone while idle must not rotate priority.
    clearPulse();
    RotatingPriority = 1'b1; DREQ = 4'b0000;
    repeat (3) serviceDone();
    DREQ = 4'b1111;
    waitGrant("idle_sd_wait", 5);
    check("idle_sd_id", ReqID, 0);

    // Asynchronous reset in the middle of a grant.
    #3;
    RESET_N = 1'b0;
    #1;
    check("arst_vld", ValidReqID, 0);
    check("arst_id", ReqID, 0);
    modelClear();
    @(negedge CLK);
    RESET_N = 1'b1;
    waitGrant("arst_regrant", 5);
    check("arst_regrant_id", ReqID, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      DREQ             = 4'($urandom_range(0, 15));
      SwReq            = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      MaskBits         = 4'($urandom_range(0, 15));
      DreqActiveLow    = ($urandom_range(0, 99) < 5) ? ~DreqActiveLow : DreqActiveLow;
      RotatingPriority = ($urandom_range(0, 99) < 5) ? ~RotatingPriority : RotatingPriority;
      ArbEnable        = ($urandom_range(0, 3) != 0);
      ServiceDone      = ($urandom_range(0, 3) == 0);
      MasterClear      = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
